// File: rtl/mux_arb_n_if.sv
// Bus bundle for the N-channel arbitrating mux.
// slave is the mux side, master drives the channels and the sink.
interface mux_arb_n_if #(
  parameter int W = 4,
  parameter int N = 4
);
  localparam int SW = ($clog2(N) > 1) ? $clog2(N) : 1;

  logic [N*W-1:0] A;
  logic [N-1:0]   A_valid;
  logic [N-1:0]   A_ready;
  logic [SW-1:0]  S;
  logic           M;
  logic [W-1:0]   F;
  logic           F_valid;
  logic           F_ready;
  logic [SW-1:0]  F_chan;
  logic [7:0]     xfer_cnt;

  modport master (
    output A, A_valid, S, M, F_ready,
    input  A_ready, F, F_valid, F_chan, xfer_cnt
  );

  modport slave (
    input  A, A_valid, S, M, F_ready,
    output A_ready, F, F_valid, F_chan, xfer_cnt
  );
endinterface

// File: rtl/mux_arb_n.sv
// N-channel mux with fixed or round-robin select
// feeding a one-entry registered output stage.
module mux_arb_n #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        rst,
  mux_arb_n_if.slave  bus
);
  localparam int SW = ($clog2(N) > 1) ? $clog2(N) : 1;
  localparam logic [SW:0] NL = (SW+1)'(N);

  logic [SW-1:0] r_ptr;
  logic [W-1:0]  r_f;
  logic [SW-1:0] r_chan;
  logic          r_fv;
  logic [7:0]    r_cnt;

  logic          w_fx_hit;
  logic          w_rr_hit;
  logic [SW-1:0] w_rr_idx;
  logic [SW:0]   w_sum;
  logic          w_gnt_hit;
  logic [SW-1:0] w_gnt_idx;
  logic [W-1:0]  w_gnt_data;
  logic          w_load_en;
  logic          w_take;
  logic          w_drain;

  // S may name a channel that does not exist when N is not 2^SW
  assign w_fx_hit = ({1'b0, bus.S} < NL) &&
                    bus.A_valid[bus.S];

  // Round-robin scan from ptr; scanning offsets high to low
  // lets the smallest offset from ptr overwrite and win.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    w_sum    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (SW+1)'(k);
      if (w_sum >= NL) w_sum = w_sum - NL;
      if (bus.A_valid[w_sum[SW-1:0]]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = w_sum[SW-1:0];
      end
    end
  end

  assign w_gnt_hit = bus.M ? w_rr_hit : w_fx_hit;
  assign w_gnt_idx = bus.M ? w_rr_idx : bus.S;

  // Select the granted channel word without modification
  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt_idx == SW'(i))
        w_gnt_data = bus.A[i*W +: W];
    end
  end

  assign w_load_en = !r_fv || bus.F_ready;
  assign w_take    = w_gnt_hit && w_load_en && !rst;
  assign w_drain   = r_fv && bus.F_ready;

  // One-hot ready, only to the granted channel
  always_comb begin
    bus.A_ready = '0;
    for (int i = 0; i < N; i++) begin
      bus.A_ready[i] = w_take && (w_gnt_idx == SW'(i));
    end
  end

  // Output register: load wins over drain, so no bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f    <= '0;
      r_chan <= '0;
      r_fv   <= 1'b0;
    end else if (w_take) begin
      r_f    <= w_gnt_data;
      r_chan <= w_gnt_idx;
      r_fv   <= 1'b1;
    end else if (w_drain) begin
      r_fv   <= 1'b0;
    end
  end

  // Round-robin pointer moves past the winner in mode 1 only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_take && bus.M) begin
      r_ptr <= (w_gnt_idx == SW'(N - 1)) ? '0
             : w_gnt_idx + 1'b1;
    end
  end

  // Completed output transfers, free-running mod 256
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_drain) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign bus.F        = r_f;
  assign bus.F_chan   = r_chan;
  assign bus.F_valid  = r_fv;
  assign bus.xfer_cnt = r_cnt;
endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: directed cases plus
// randomized traffic against a transaction model.
module tb_mux_arb_n;
  localparam int W = 4;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_arb_n_if #(.W(W), .N(N)) u_if ();

  mux_arb_n #(.W(W), .N(N)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic         m_fv;
  logic [W-1:0] m_f;
  int           m_ch;
  int           m_ptr;
  int           m_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int grant();
    if (!u_if.M) begin
      if (int'(u_if.S) < N && u_if.A_valid[u_if.S])
        return int'(u_if.S);
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (u_if.A_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_fv  = 1'b0;
    m_f   = '0;
    m_ch  = 0;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  task automatic step();
    int g;
    logic ld;
    logic [N-1:0] er;
    @(negedge clk);
    ld = !m_fv || u_if.F_ready;
    g  = grant();
    er = (g >= 0 && ld) ? (N'(1) << g) : '0;
    chk("A_ready", 32'(u_if.A_ready), 32'(er));
    chk("F_valid", 32'(u_if.F_valid), 32'(m_fv));
    chk("F", 32'(u_if.F), 32'(m_f));
    chk("F_chan", 32'(u_if.F_chan), m_ch);
    chk("xfer_cnt", 32'(u_if.xfer_cnt), m_cnt);
    if (m_fv && u_if.F_ready) m_cnt = (m_cnt + 1) % 256;
    if (g >= 0 && ld) begin
      m_f  = u_if.A[g*W +: W];
      m_ch = g;
      m_fv = 1'b1;
      if (u_if.M) m_ptr = (g + 1) % N;
    end else if (m_fv && u_if.F_ready) begin
      m_fv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_F_valid", 32'(u_if.F_valid), 0);
    chk("rst_F", 32'(u_if.F), 0);
    chk("rst_F_chan", 32'(u_if.F_chan), 0);
    chk("rst_xfer", 32'(u_if.xfer_cnt), 0);
    chk("rst_A_ready", 32'(u_if.A_ready), 0);
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int seq35 [6] = '{0, 1, 2, 3, 0, 1};
  int seq36 [4] = '{1, 3, 1, 3};

  initial begin
    rst          = 1'b0;
    u_if.A       = '0;
    u_if.A_valid = '0;
    u_if.S       = '0;
    u_if.M       = 1'b0;
    u_if.F_ready = 1'b0;
    model_clear();
    do_reset();

    // fixed select, channel 1
    u_if.M       = 1'b0;
    u_if.A       = {4'b1011, 4'b1001, 4'b0010, 4'b0001};
    u_if.A_valid = 4'b1111;
    u_if.S       = 2'd1;
    u_if.F_ready = 1'b1;
    #1 chk("m0_ardy", 32'(u_if.A_ready), 32'h2);
    step();
    chk("m0_F", 32'(u_if.F), 32'h2);
    chk("m0_chan", 32'(u_if.F_chan), 1);

    // selected channel not valid: drain then idle
    u_if.S       = 2'd2;
    u_if.A_valid = 4'b1011;
    #1 chk("m0_noardy", 32'(u_if.A_ready), 0);
    step();
    chk("m0_drained", 32'(u_if.F_valid), 0);

    // round robin, all valid
    do_reset();
    u_if.M       = 1'b1;
    u_if.A_valid = 4'b1111;
    u_if.F_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_seq", 32'(u_if.F_chan), seq35[i]);
    end
    chk("rr_cnt", 32'(u_if.xfer_cnt), 5);

    // round robin, sparse valid
    do_reset();
    u_if.M       = 1'b1;
    u_if.A_valid = 4'b1010;
    u_if.F_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_sparse", 32'(u_if.F_chan), seq36[i]);
    end

    // backpressure holds word 0110
    u_if.M       = 1'b0;
    u_if.S       = 2'd0;
    u_if.A       = {4'b1111, 4'b1100, 4'b1010, 4'b0110};
    u_if.A_valid = 4'b0001;
    u_if.F_ready = 1'b1;
    step();
    u_if.F_ready = 1'b0;
    u_if.A_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      int c0;
      c0 = m_cnt;
      #1 chk("bp_ardy", 32'(u_if.A_ready), 0);
      step();
      chk("bp_F", 32'(u_if.F), 32'h6);
      chk("bp_chan", 32'(u_if.F_chan), 0);
      chk("bp_fv", 32'(u_if.F_valid), 1);
      chk("bp_cnt", 32'(u_if.xfer_cnt), c0);
    end

    // reset mid-cycle with a held word
    do_reset();

    // random traffic, occasional mid-cycle resets early on
    for (int i = 0; i < 900; i++) begin
      u_if.A       = W*N'($urandom);
      u_if.A_valid = N'($urandom);
      u_if.S       = 2'($urandom);
      u_if.M       = 1'($urandom_range(0, 1));
      u_if.F_ready = ($urandom_range(0, 3) != 0);
      if (i < 200 && $urandom_range(0, 59) == 0)
        do_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mux_arb_n.md
MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 Parameter W, default 4, data width per channel in bits (W >= 1).
REQ-002 Parameter N, default 4, number of input channels (N >= 2); SW = max(1, clog2(N)).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 A  input  N*W  channel data; channel i occupies bits [i*W +: W].
REQ-006 A_valid  input  N  per-channel valid.
REQ-007 A_ready  output  N  per-channel ready, combinational.
REQ-008 S  input  SW  channel select, used in mode 0.
REQ-009 M  input  1  mode: 0 = fixed select by S, 1 = round-robin.
REQ-010 F  output  W  registered output data.
REQ-011 F_valid  output  1  output register holds a word.
REQ-012 F_ready  input  1  downstream accepts F.
REQ-013 F_chan  output  SW  channel index the word in F came from.
REQ-014 xfer_cnt  output  8  count of completed output transfers.

Function
REQ-015 The block SHALL hold a one-entry output register (F, F_chan, F_valid).
REQ-016 load_en SHALL be (!F_valid) || F_ready.
REQ-017 Mode 0: grant is channel S when S < N and A_valid[S] = 1; otherwise no grant.
REQ-018 Mode 1: grant is the first i with A_valid[i] = 1, searching ptr, ptr+1, ... mod N; no grant when A_valid = 0.
REQ-019 A_ready[i] SHALL be 1 only when i is the granted channel and load_en = 1; at most one A_ready bit is high.
REQ-020 On a cycle with a grant and load_en = 1: next F = granted data, F_chan = granted index, F_valid = 1.
REQ-021 Latency SHALL be one cycle: input handshake at edge k gives F_valid = 1 after edge k.
REQ-022 When F_valid = 1 and F_ready = 1 with no grant, F_valid SHALL clear; F and F_chan hold their values.
REQ-023 When F_valid = 1 and F_ready = 0, F, F_chan and F_valid SHALL hold; all A_ready = 0.
REQ-024 Simultaneous drain and load (F_ready = 1, grant present) SHALL replace the word with no bubble, sustaining one word per cycle.
REQ-025 ptr (SW bits) SHALL update to (granted index + 1) mod N only on an input handshake in mode 1; wraps N-1 -> 0.
REQ-026 In mode 0, ptr SHALL hold.
REQ-027 A change of M or S SHALL affect only the next arbitration; a held output word is unaffected.
REQ-028 xfer_cnt SHALL increment by 1 on each edge with F_valid = 1 and F_ready = 1, and wrap 255 -> 0.
REQ-029 Input data SHALL not be modified; F equals the selected channel word bit-exactly.

Reset
REQ-030 While rst = 1: F = 0, F_chan = 0, F_valid = 0, ptr = 0, xfer_cnt = 0, and all A_ready = 0, regardless of clk.
REQ-031 Reset asserted mid-transfer SHALL discard the held word immediately, with no handshake completed.
REQ-032 After rst deasserts, the first grant SHALL be possible at the next rising edge.

Verification (N=4, W=4)
REQ-033 Mode 0: A = {1011,1001,0010,0001}, all valid, S = 1, F_ready = 1 -> A_ready = 0010; F = 0010, F_chan = 1 one cycle later.
REQ-034 Mode 0: S = 2, A_valid[2] = 0 -> A_ready = 0000; F_valid falls after the pending word drains.
REQ-035 Mode 1: all valid, F_ready = 1 for 6 cycles from reset -> F_chan sequence 0,1,2,3,0,1; xfer_cnt = 5 after the 6th edge.
REQ-036 Mode 1: A_valid = 1010, F_ready = 1 -> F_chan alternates 1,3,1,3; channels 0 and 2 are never granted.
REQ-037 Backpressure: F holds 0110, F_ready = 0 for 3 cycles -> F, F_chan stable; A_ready = 0000; xfer_cnt unchanged.
REQ-038 Reset with F_valid = 1 and rst pulsed between edges -> F_valid = 0, F = 0000, xfer_cnt = 0 immediately, before the next edge.
